bus_memory_responder: RTL and testbench

BUS_MEMORY_RESPONDER -- requirements
Module: bus_memory_responder

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_memory_responder_if.sv | 33 +++
 rtl/bus_responder_sram.sv | 28 ++
 rtl/bus_memory_responder.sv | 151 +++++++++++++++
 tb/tb_bus_memory_responder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state type, beat-counter width and address-decode helper for the memory responder.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package bus_pkg;

   localparam int BEAT_CNT_W = 9;

   typedef enum logic [2:0] {
      IDLE,
      READ_ADDR,
      READ_BURST,
      READ_END,
      WRITE_BURST,
      ERROR
   } state_t;

   // True when the word-aligned address falls inside [base, base+span); 33-bit math avoids wrap at the top of the map.
   function automatic logic addr_match(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [32:0] span);
      logic [32:0] a;
      logic [32:0] lo;
      a  = {1'b0, addr & 32'hFFFF_FFFC};
      lo = {1'b0, base};
      return (a >= lo) && (a < lo + span);
   endfunction

endpackage

// File: rtl/bus_memory_responder_if.sv
// bus_memory_responder_if: initiator/responder signal bundle for the burst memory bus.
// Latency: none (wiring only).
// Backpressure: busOut_busy is the only stall signal carried here.
interface bus_memory_responder_if;

   logic        busIn_begin_transaction;
   logic [31:0] busIn_address_data;
   logic [7:0]  busIn_burst_size;
   logic        busIn_read_n_write;
   logic [3:0]  busIn_byte_enable;
   logic        busIn_data_valid;
   logic        busIn_end_transaction;
   logic [31:0] busOut_address_data;
   logic        busOut_data_valid;
   logic        busOut_end_transaction;
   logic        busOut_busy;
   logic        busOut_error;

   modport master (
      output busIn_begin_transaction, busIn_address_data, busIn_burst_size,
             busIn_read_n_write, busIn_byte_enable, busIn_data_valid, busIn_end_transaction,
      input  busOut_address_data, busOut_data_valid, busOut_end_transaction,
             busOut_busy, busOut_error
   );

   modport slave (
      input  busIn_begin_transaction, busIn_address_data, busIn_burst_size,
             busIn_read_n_write, busIn_byte_enable, busIn_data_valid, busIn_end_transaction,
      output busOut_address_data, busOut_data_valid, busOut_end_transaction,
             busOut_busy, busOut_error
   );

endinterface

// File: rtl/bus_responder_sram.sv
// bus_responder_sram: single-port 32-bit word RAM with per-byte write enables.
// Latency: read data valid one cycle after an enabled non-write access.
// Backpressure: none; accepts one access per cycle.
module bus_responder_sram #(
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Byte-lane writes, or a registered read when no lane is enabled; contents survive reset.
   always_ff @(posedge clock) begin
      if (en) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
         if (we == 4'b0000) rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: burst-bus memory target; BUS_MEMORY_RESPONDER_ERROR_EN adds error responses.
// Latency: first read beat 2 cycles after begin, one beat per cycle, end pulse 1 cycle after the last beat.
// Backpressure: busOut_busy stalls the initiator for the single cycle after a claimed write begin.
module bus_memory_responder
   import bus_pkg::*;
#(
   parameter logic [31:0] baseAddress = 32'h5000_0000,
   parameter int          nrOfWords   = 512
) (
   input logic                   clock,
   input logic                   reset,
   bus_memory_responder_if.slave bus
);

   localparam int          IDX_W = $clog2(nrOfWords);
   localparam logic [32:0] SPAN  = 33'(nrOfWords) * 33'd4;

   state_t                  state_q, state_nxt;
   logic [IDX_W-1:0]        idx_q, idx_nxt;
   logic [BEAT_CNT_W-1:0]   cnt_q, cnt_nxt;
   logic                    excess_q, excess_nxt;
   logic                    busy_q, busy_nxt;
   logic                    hit;
   logic [IDX_W-1:0]        begin_idx;
   logic                    ram_en;
   logic [3:0]              ram_we;
   logic [IDX_W-1:0]        ram_addr;
   logic [31:0]             ram_rdata;
   logic                    rd_vld;

   assign hit       = addr_match(bus.busIn_address_data, baseAddress, SPAN);
   // Only the low index bits of the offset matter since the index wraps modulo the depth.
   assign begin_idx = bus.busIn_address_data[IDX_W+1:2] - baseAddress[IDX_W+1:2];

   // State and datapath registers; reset clears everything except the memory array.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         excess_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         idx_q    <= idx_nxt;
         cnt_q    <= cnt_nxt;
         excess_q <= excess_nxt;
         busy_q   <= busy_nxt;
      end
   end

   // Next-state, counter updates and RAM control for read/write bursts.
   always_comb begin
      state_nxt  = state_q;
      idx_nxt    = idx_q;
      cnt_nxt    = cnt_q;
      excess_nxt = excess_q;
      busy_nxt   = 1'b0;
      ram_en     = 1'b0;
      ram_we     = 4'b0000;
      ram_addr   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (bus.busIn_begin_transaction) begin
               if (hit) begin
                  idx_nxt    = begin_idx;
                  cnt_nxt    = BEAT_CNT_W'(bus.busIn_burst_size) + BEAT_CNT_W'(1);
                  excess_nxt = 1'b0;
                  if (bus.busIn_read_n_write) begin
                     state_nxt = READ_ADDR;
                  end else begin
                     state_nxt = WRITE_BURST;
                     busy_nxt  = 1'b1;
                  end
               end
`ifdef BUS_MEMORY_RESPONDER_ERROR_EN
               else begin
                  state_nxt = ERROR;
               end
`endif
            end
         end
         READ_ADDR: begin
            ram_en    = 1'b1;
            idx_nxt   = idx_q + IDX_W'(1);
            state_nxt = READ_BURST;
         end
         READ_BURST: begin
            cnt_nxt = cnt_q - BEAT_CNT_W'(1);
            if (cnt_q == BEAT_CNT_W'(1)) begin
               state_nxt = READ_END;
            end else begin
               // Prefetch the next word so beats stay back-to-back.
               ram_en  = 1'b1;
               idx_nxt = idx_q + IDX_W'(1);
            end
         end
         READ_END: begin
            state_nxt = IDLE;
         end
         WRITE_BURST: begin
            if (!busy_q && bus.busIn_data_valid) begin
               if (cnt_q != '0) begin
                  ram_en  = 1'b1;
                  ram_we  = bus.busIn_byte_enable;
                  cnt_nxt = cnt_q - BEAT_CNT_W'(1);
                  idx_nxt = idx_q + IDX_W'(1);
               end else begin
                  excess_nxt = 1'b1;
               end
            end
            if (bus.busIn_end_transaction) begin
               state_nxt = IDLE;
`ifdef BUS_MEMORY_RESPONDER_ERROR_EN
               if (excess_nxt) state_nxt = ERROR;
`endif
            end
         end
         ERROR: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   bus_responder_sram #(
      .DEPTH (nrOfWords),
      .AW    (IDX_W)
   ) u_sram (
      .clock (clock),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (bus.busIn_address_data),
      .rdata (ram_rdata)
   );

   assign rd_vld                     = (state_q == READ_BURST);
   assign bus.busOut_data_valid      = rd_vld;
   assign bus.busOut_address_data    = rd_vld ? ram_rdata : 32'h0;
   assign bus.busOut_end_transaction = (state_q == READ_END) || (state_q == ERROR);
   assign bus.busOut_busy            = busy_q;
`ifdef BUS_MEMORY_RESPONDER_ERROR_EN
   assign bus.busOut_error           = (state_q == ERROR);
`else
   assign bus.busOut_error           = 1'b0;
`endif

endmodule

// File: tb/tb_bus_memory_responder.sv
// tb_bus_memory_responder: scoreboard bench for the burst memory responder.
// Latency: expects read beats at begin+2.., end at begin+beats+2, errors at begin+1 or write end+1.
// Backpressure: checks busy appears only in the cycle after a claimed write begin.
module tb_bus_memory_responder;

   localparam logic [31:0] BASE = 32'h5000_0000;
   localparam int          N    = 512;

   typedef struct {int cyc; logic [31:0] dat;} beat_t;
   typedef struct {int cyc; logic err;} end_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   int          busy_cyc = -1;
   beat_t       rd_q[$];
   end_t        end_q[$];
   logic [31:0] model [N];
   logic [31:0] wdat[$];

   bus_memory_responder_if bus();

   bus_memory_responder #(
      .baseAddress (BASE),
      .nrOfWords   (N)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Output monitor: pops the scoreboards whenever the responder produces a beat or an end pulse.
   always @(negedge clock) begin
      beat_t b;
      end_t  e;
      if (bus.busOut_data_valid) begin
         if (rd_q.size() == 0) begin
            chk("spurious_beat", 1, 0);
         end else begin
            b = rd_q.pop_front();
            chk("beat_cyc", cyc, b.cyc);
            chk("beat_dat", bus.busOut_address_data, b.dat);
         end
      end else begin
         chk("idle_data", bus.busOut_address_data, 0);
      end
      if (bus.busOut_end_transaction) begin
         if (end_q.size() == 0) begin
            chk("spurious_end", 1, 0);
         end else begin
            e = end_q.pop_front();
            chk("end_cyc", cyc, e.cyc);
            chk("end_err", bus.busOut_error, e.err);
         end
      end else if (bus.busOut_error) begin
         chk("err_without_end", 1, 0);
      end
      if (bus.busOut_busy) chk("busy_cyc", cyc, busy_cyc);
   end

   task automatic wait_drain(input int budget);
      int i = 0;
      while ((rd_q.size() != 0 || end_q.size() != 0) && i < budget) begin
         tick;
         i++;
      end
      repeat (3) tick;
      chk("drain", rd_q.size() + end_q.size(), 0);
      rd_q.delete();
      end_q.delete();
   endtask

   task automatic do_write(input int word, input int burst, input logic [3:0] be,
                           input int nbeats, input logic oob);
      int k;
      int w;
      k = cyc;
      bus.busIn_begin_transaction = 1'b1;
      bus.busIn_address_data = (oob ? BASE + 32'(N * 4) : BASE + 32'(word * 4)) + 32'($urandom_range(0, 3));
      bus.busIn_read_n_write = 1'b0;
      bus.busIn_burst_size   = 8'(burst);
      bus.busIn_byte_enable  = be;
      if (!oob) busy_cyc = k + 1;
`ifdef BUS_MEMORY_RESPONDER_ERROR_EN
      if (oob) end_q.push_back('{k + 1, 1'b1});
`endif
      tick;
      bus.busIn_begin_transaction = 1'b0;
      chk("busy_after_begin", bus.busOut_busy, oob ? 0 : 1);
      // A beat offered during the busy cycle must be dropped.
      bus.busIn_data_valid   = 1'b1;
      bus.busIn_address_data = 32'hDEAD_BEEF;
      bus.busIn_byte_enable  = 4'hF;
      tick;
      for (int i = 0; i < nbeats; i++) begin
         bus.busIn_data_valid      = 1'b1;
         bus.busIn_address_data    = wdat[i];
         bus.busIn_byte_enable     = be;
         bus.busIn_end_transaction = (i == nbeats - 1);
         if (!oob && i <= burst) begin
            w = (word + i) % N;
            for (int b = 0; b < 4; b++) begin
               if (be[b]) model[w][8*b +: 8] = wdat[i][8*b +: 8];
            end
         end
         tick;
      end
      bus.busIn_data_valid      = 1'b0;
      bus.busIn_end_transaction = 1'b0;
`ifdef BUS_MEMORY_RESPONDER_ERROR_EN
      if (!oob && nbeats > burst + 1) end_q.push_back('{cyc, 1'b1});
`endif
      wait_drain(8);
   endtask

   task automatic do_read(input int word, input int burst, input logic oob, input logic poke);
      int k;
      k = cyc;
      bus.busIn_begin_transaction = 1'b1;
      bus.busIn_address_data = (oob ? BASE + 32'(N * 4) : BASE + 32'(word * 4)) + 32'($urandom_range(0, 3));
      bus.busIn_read_n_write = 1'b1;
      bus.busIn_burst_size   = 8'(burst);
      bus.busIn_byte_enable  = 4'($urandom);
      if (!oob) begin
         for (int i = 0; i <= burst; i++) rd_q.push_back('{k + 2 + i, model[(word + i) % N]});
         end_q.push_back('{k + burst + 3, 1'b0});
      end
`ifdef BUS_MEMORY_RESPONDER_ERROR_EN
      else end_q.push_back('{k + 1, 1'b1});
`endif
      tick;
      bus.busIn_begin_transaction = 1'b0;
      if (poke) begin
         // A write begin in the middle of the read burst must be ignored.
         tick;
         bus.busIn_begin_transaction = 1'b1;
         bus.busIn_read_n_write      = 1'b0;
         bus.busIn_address_data      = BASE;
         tick;
         bus.busIn_begin_transaction = 1'b0;
      end
      wait_drain(burst + 10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1);
   end

   initial begin
      int k;
      bus.busIn_begin_transaction = 1'b0;
      bus.busIn_address_data      = 32'h0;
      bus.busIn_burst_size        = 8'h0;
      bus.busIn_read_n_write      = 1'b0;
      bus.busIn_byte_enable       = 4'h0;
      bus.busIn_data_valid        = 1'b0;
      bus.busIn_end_transaction   = 1'b0;
      repeat (3) tick;
      chk("rst_data", bus.busOut_address_data, 0);
      chk("rst_ctl", {bus.busOut_busy, bus.busOut_error, bus.busOut_end_transaction, bus.busOut_data_valid}, 0);
      reset = 1'b1;
      tick;

      // Wrap: a write and a read that cross from the last word to word 0.
      wdat = '{32'hA5A5_01FF, 32'h5A5A_0000};
      do_write(N - 1, 1, 4'hF, 2, 1'b0);
      do_read(N - 1, 1, 1'b0, 1'b0);

      // Four-beat burst write then read with a mid-burst begin poke.
      wdat = '{32'h11, 32'h22, 32'h33, 32'h44};
      do_write(0, 3, 4'hF, 4, 1'b0);
      do_read(0, 3, 1'b0, 1'b1);

      // Masked write over zero.
      wdat = '{32'h0};
      do_write(5, 0, 4'hF, 1, 1'b0);
      wdat = '{32'hAABB_CCDD};
      do_write(5, 0, 4'b0101, 1, 1'b0);
      do_read(5, 0, 1'b0, 1'b0);

      // Out-of-range write and read, then confirm memory untouched.
      wdat = '{32'hBAD0_BAD0};
      do_write(0, 0, 4'hF, 1, 1'b1);
      do_read(0, 0, 1'b1, 1'b0);
      do_read(0, 3, 1'b0, 1'b0);

      // Excess write beats are dropped.
      wdat = '{32'h77, 32'h88, 32'h99};
      do_write(0, 0, 4'hF, 3, 1'b0);
      do_read(0, 2, 1'b0, 1'b0);

      // Reset during the second beat of a four-beat read.
      k = cyc;
      bus.busIn_begin_transaction = 1'b1;
      bus.busIn_address_data      = BASE;
      bus.busIn_read_n_write      = 1'b1;
      bus.busIn_burst_size        = 8'd3;
      rd_q.push_back('{k + 2, model[0]});
      tick;
      bus.busIn_begin_transaction = 1'b0;
      tick;
      tick;
      chk("pre_rst_vld", bus.busOut_data_valid, 1);
      reset = 1'b0;
      #1;
      chk("rst_mid_data", bus.busOut_address_data, 0);
      chk("rst_mid_ctl", {bus.busOut_busy, bus.busOut_error, bus.busOut_end_transaction, bus.busOut_data_valid}, 0);
      tick;
      tick;
      reset = 1'b1;
      wait_drain(4);
      do_read(0, 3, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
